// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for a 1280x1024@60 Hz display on a 108 MHz pixel
// clock. Free-running horizontal/vertical counters publish the pixel
// coordinate to the renderer. The renderer's combinational colour is
// registered, together with sync and blanking, so every DAC-side signal
// leaves the block on the same edge.
//
// Ports
//   pixelClock      in   1   pixel clock, rising edge
//   resetN          in   1   asynchronous reset, active low
//   redIn           in   8   renderer red for the current X/Y position
//   greenIn         in   8   renderer green for the current X/Y position
//   blueIn          in   8   renderer blue for the current X/Y position
//   XPixelPosition  out  11  horizontal counter, 0..HTotal-1
//   YPixelPosition  out  11  vertical counter, 0..VTotal-1
//   VGA_R/G/B       out  8   registered colour, zero outside active video
//   VGA_HS          out  1   horizontal sync, aligned with VGA_R/G/B
//   VGA_VS          out  1   vertical sync, aligned with VGA_R/G/B
//   VGA_BLANK_N     out  1   high during active video, aligned with VGA_R/G/B
//   frameTick       out  1   one-cycle pulse at the start of vertical blanking
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned HVisible = 1280,
    parameter int unsigned HFront   = 48,
    parameter int unsigned HSyncW   = 112,
    parameter int unsigned HBack    = 248,
    parameter int unsigned VVisible = 1024,
    parameter int unsigned VFront   = 1,
    parameter int unsigned VSyncW   = 3,
    parameter int unsigned VBack    = 38,
    parameter logic        HSyncPol = 1'b1,
    parameter logic        VSyncPol = 1'b1
) (
    input  logic        pixelClock,
    input  logic        resetN,
    input  logic [7:0]  redIn,
    input  logic [7:0]  greenIn,
    input  logic [7:0]  blueIn,
    output logic [10:0] XPixelPosition,
    output logic [10:0] YPixelPosition,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        frameTick
);

    // Raster geometry. Totals must fit the 11-bit counters (<= 2048).
    localparam int unsigned HTotal = HVisible + HFront + HSyncW + HBack;
    localparam int unsigned VTotal = VVisible + VFront + VSyncW + VBack;

    // All decode constants are pre-sized to the counter width so every
    // comparison below is a plain 11-bit compare.
    localparam logic [10:0] HLast      = 11'(HTotal - 1);
    localparam logic [10:0] HActEnd    = 11'(HVisible);
    localparam logic [10:0] HSyncStart = 11'(HVisible + HFront);
    localparam logic [10:0] HSyncEnd   = 11'(HVisible + HFront + HSyncW);

    localparam logic [10:0] VLast      = 11'(VTotal - 1);
    localparam logic [10:0] VActEnd    = 11'(VVisible);
    localparam logic [10:0] VSyncStart = 11'(VVisible + VFront);
    localparam logic [10:0] VSyncEnd   = 11'(VVisible + VFront + VSyncW);

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        x_wrap;
    logic        y_wrap;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        x_wrap = (x_q == HLast);
        y_wrap = (y_q == VLast);
        x_d    = x_q + 11'd1;
        y_d    = y_q;
        if (x_wrap) begin
            x_d = '0;
            // Line and frame wrap share the same edge: (HLast,VLast) -> (0,0).
            y_d = y_wrap ? '0 : y_q + 11'd1;
        end
    end

    // ------------------------------------------------------------------
    // Stage-0 decode, straight from the counters
    // ------------------------------------------------------------------
    logic active;
    logic hs_on;
    logic vs_on;
    logic tick_d;

    always_comb begin
        active = (x_q < HActEnd) && (y_q < VActEnd);
        hs_on  = (x_q >= HSyncStart) && (x_q < HSyncEnd);
        vs_on  = (y_q >= VSyncStart) && (y_q < VSyncEnd);
        // First pixel of the first blanked line: safe point for game state.
        tick_d = (x_q == '0) && (y_q == VActEnd);
    end

    // ------------------------------------------------------------------
    // Output stage: one register for colour, sync, blank and tick so the
    // DAC sees them mutually aligned, one cycle after the coordinate.
    // ------------------------------------------------------------------
    logic [7:0] red_d,   red_q;
    logic [7:0] green_d, green_q;
    logic [7:0] blue_d,  blue_q;
    logic       hs_d,    hs_q;
    logic       vs_d,    vs_q;
    logic       blank_n_q;
    logic       tick_q;

    always_comb begin
        // Renderer colour outside the active window never reaches the DAC.
        red_d   = active ? redIn   : 8'h00;
        green_d = active ? greenIn : 8'h00;
        blue_d  = active ? blueIn  : 8'h00;
        hs_d    = hs_on ? HSyncPol : ~HSyncPol;
        vs_d    = vs_on ? VSyncPol : ~VSyncPol;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            x_q       <= '0;
            y_q       <= '0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
            hs_q      <= ~HSyncPol;
            vs_q      <= ~VSyncPol;
            blank_n_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= active;
            tick_q    <= tick_d;
        end
    end

    assign XPixelPosition = x_q;
    assign YPixelPosition = y_q;
    assign VGA_R          = red_q;
    assign VGA_G          = green_q;
    assign VGA_B          = blue_q;
    assign VGA_HS         = hs_q;
    assign VGA_VS         = vs_q;
    assign VGA_BLANK_N    = blank_n_q;
    assign frameTick      = tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Scoreboard bench for vga_timing_gen on a scaled-down raster so several
// frames fit in a short run. The stimulus process drives reset and colour
// once per cycle and pushes the expected observation for that cycle; the
// monitor pops one record per cycle on the falling edge and compares.
// Expected values come from the raster position derived from a plain count
// of cycles since reset release.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int HV = 40;
    localparam int HF = 3;
    localparam int HS = 5;
    localparam int HB = 6;
    localparam int HT = HV + HF + HS + HB;
    localparam int VV = 12;
    localparam int VF = 1;
    localparam int VS = 3;
    localparam int VB = 4;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic HPOL = 1'b1;
    localparam logic VPOL = 1'b0;

    // Position at which the mid-frame reset lands.
    localparam int MIDX = 22;
    localparam int MIDY = 7;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        hs;
        logic        vs;
        logic        blank_n;
        logic        tick;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  red = 8'h00;
    logic [7:0]  green = 8'h00;
    logic [7:0]  blue = 8'h00;
    logic [10:0] x_pos;
    logic [10:0] y_pos;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic        frame_tick;

    vga_timing_gen #(
        .HVisible(HV), .HFront(HF), .HSyncW(HS), .HBack(HB),
        .VVisible(VV), .VFront(VF), .VSyncW(VS), .VBack(VB),
        .HSyncPol(HPOL), .VSyncPol(VPOL)
    ) dut (
        .pixelClock    (clk),
        .resetN        (rst_n),
        .redIn         (red),
        .greenIn       (green),
        .blueIn        (blue),
        .XPixelPosition(x_pos),
        .YPixelPosition(y_pos),
        .VGA_R         (vga_r),
        .VGA_G         (vga_g),
        .VGA_B         (vga_b),
        .VGA_HS        (vga_hs),
        .VGA_VS        (vga_vs),
        .VGA_BLANK_N   (vga_blank_n),
        .frameTick     (frame_tick)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic obs_t reset_obs();
        obs_t o;
        o         = '0;
        o.hs      = ~HPOL;
        o.vs      = ~VPOL;
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Reference model state: cycles since release, and the DAC-side values
    // owed on the next cycle.
    // ------------------------------------------------------------------
    int   n = 0;
    obs_t pend;

    task automatic step(input bit rst, input bit white);
        obs_t e;
        int   p;
        int   x;
        int   y;
        @(posedge clk);
        #1;
        rst_n = ~rst;
        if (white) begin
            red   = 8'hFF;
            green = 8'hFF;
            blue  = 8'hFF;
        end else begin
            red   = 8'($urandom);
            green = 8'($urandom);
            blue  = 8'($urandom);
        end
        if (rst) begin
            e    = reset_obs();
            pend = reset_obs();
            n    = 0;
        end else begin
            p     = n % FRAME;
            x     = p % HT;
            y     = p / HT;
            e     = pend;
            e.x   = 11'(x);
            e.y   = 11'(y);
            pend.x       = '0;
            pend.y       = '0;
            pend.blank_n = (x < HV) && (y < VV);
            pend.r       = pend.blank_n ? red   : 8'h00;
            pend.g       = pend.blank_n ? green : 8'h00;
            pend.b       = pend.blank_n ? blue  : 8'h00;
            pend.hs      = (x >= HV + HF && x < HV + HF + HS) ? HPOL : ~HPOL;
            pend.vs      = (y >= VV + VF && y < VV + VF + VS) ? VPOL : ~VPOL;
            pend.tick    = (p == VV * HT);
            n++;
        end
        exp_q.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Monitor: per-cycle comparison plus frame-level properties.
    // ------------------------------------------------------------------
    int mon_cycle = 0;
    bit have_prev = 1'b0;
    int last_tick = 0;
    int vs_cnt = 0;
    bit rel_armed = 1'b0;
    int rel_cnt = 0;

    initial begin
        obs_t e;
        obs_t got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e           = exp_q.pop_front();
                got.x       = x_pos;
                got.y       = y_pos;
                got.r       = vga_r;
                got.g       = vga_g;
                got.b       = vga_b;
                got.hs      = vga_hs;
                got.vs      = vga_vs;
                got.blank_n = vga_blank_n;
                got.tick    = frame_tick;
                check($sformatf("obs@%0d", mon_cycle), 64'(got), 64'(e));

                if (!rst_n) begin
                    have_prev = 1'b0;
                    vs_cnt    = 0;
                    rel_armed = 1'b1;
                    rel_cnt   = 0;
                end else begin
                    if (vga_vs == VPOL) vs_cnt++;
                    if (frame_tick) begin
                        if (have_prev) begin
                            check("tick_period", 64'(mon_cycle - last_tick), 64'(FRAME));
                            check("vs_cycles_per_frame", 64'(vs_cnt), 64'(VS * HT));
                        end
                        have_prev = 1'b1;
                        last_tick = mon_cycle;
                        vs_cnt    = 0;
                    end
                    if (rel_armed) begin
                        if (frame_tick || rel_cnt > VV * HT + 1) begin
                            check("first_tick_after_release", 64'(rel_cnt), 64'(VV * HT + 1));
                            rel_armed = 1'b0;
                        end
                        rel_cnt++;
                    end
                end
                mon_cycle++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        pend = reset_obs();
        // Power-up reset with full-white colour held on the renderer inputs.
        repeat (5) step(1'b1, 1'b1);
        // First frame full white exercises blank gating; then random colour.
        repeat (FRAME) step(1'b0, 1'b1);
        repeat (FRAME + 10) step(1'b0, 1'b0);
        // Mid-frame reset landing on (MIDX, MIDY), held three cycles.
        while ((n % FRAME) != MIDY * HT + MIDX) step(1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        repeat (VV * HT + 20) step(1'b0, 1'b0);
        // Random reset pulses at random raster positions.
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(1, 2 * FRAME)) step(1'b0, 1'b0);
            repeat ($urandom_range(1, 4)) step(1'b1, 1'b0);
        end
        repeat (2 * FRAME + 50) step(1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator that drives the pixel-coordinate bus consumed by the pong renderer and turns the renderer's combinational RGB back into a registered, sync-aligned VGA output. Runs on the 108 MHz pixel clock for 1280x1024@60 Hz. Produces horizontal and vertical counters, sync pulses, a blanking flag and a once-per-frame tick for game logic. It sits between the renderer and the DE2 video DAC pins.

## Interface
Parameters:
- HVisible, 1280, active pixels per line
- HFront, 48, horizontal front porch (pixels)
- HSyncW, 112, horizontal sync width
- HBack, 248, horizontal back porch; HTotal = 1688
- VVisible, 1024, active lines per frame
- VFront, 1, vertical front porch (lines)
- VSyncW, 3, vertical sync width
- VBack, 38, vertical back porch; VTotal = 1066
- HSyncPol, 1'b1, active level of VGA_HS
- VSyncPol, 1'b1, active level of VGA_VS

Ports:
- pixelClock  in  1  pixel clock, rising edge
- resetN  in  1  asynchronous reset, active low
- redIn, greenIn, blueIn  in  8 each  renderer colour for the current XPixelPosition/YPixelPosition
- XPixelPosition  out  11  horizontal counter, 0..HTotal-1
- YPixelPosition  out  11  vertical counter, 0..VTotal-1
- VGA_R, VGA_G, VGA_B  out  8 each  registered colour to DAC
- VGA_HS  out  1  horizontal sync, aligned with VGA_R/G/B
- VGA_VS  out  1  vertical sync, aligned with VGA_R/G/B
- VGA_BLANK_N  out  1  high during active video, aligned with VGA_R/G/B
- frameTick  out  1  one-cycle pulse per frame

## Operation
- Counters: XPixelPosition increments every cycle. At HTotal-1 it wraps to 0, and YPixelPosition increments in the same edge. YPixelPosition wraps to 0 when X wraps while Y = VTotal-1. Both are plain 11-bit registers; HTotal and VTotal must be ≤ 2048.
- Stage-0 decode, combinational from the counters:
  - active = (X < HVisible) && (Y < VVisible)
  - hs = (X >= HVisible+HFront) && (X < HVisible+HFront+HSyncW), i.e. 1328..1439
  - vs = (Y >= VVisible+VFront) && (Y < VVisible+VFront+VSyncW), i.e. 1025..1027
- Output stage, registered every edge:
  - VGA_BLANK_N <= active
  - VGA_HS <= hs ? HSyncPol : ~HSyncPol; VGA_VS likewise with VSyncPol
  - VGA_R/G/B <= active ? redIn/greenIn/blueIn : 0
- Colour from the renderer outside the active region (e.g. the side bars at X ≥ 1180 continuing into blanking) never reaches the DAC.
- frameTick is registered. It is high for exactly one cycle: the cycle after the counters read X=0, Y=VVisible (start of vertical blanking). Game logic may update positions there without tearing.

## Timing
- Reset (resetN low, asynchronous): X=0, Y=0, VGA_R/G/B=0, VGA_BLANK_N=0, VGA_HS=~HSyncPol, VGA_VS=~VSyncPol, frameTick=0. These values are held while resetN is low.
- Counters present (0,0) during the first cycle after resetN deasserts.
- Latency:
  - Renderer inputs are sampled in the same cycle as the X/Y they correspond to.
  - VGA_* outputs reflect that position one cycle later.
  - Sync/blank are delayed by the same single register, so all DAC-side signals are mutually aligned.
- Line period 1688 cycles; frame period 1688×1066 = 1,799,408 cycles.
- Simultaneous line and frame wrap at (1687,1065) → (0,0) in one edge; no extra cycle.
- Reset asserted mid-frame: all outputs take reset values immediately, with no partial line completion. Counting restarts from (0,0) on release.
- Renderer combinational path (X/Y register → redIn → VGA_R register) must close in one 108 MHz cycle.

## Test plan
- Reset: hold resetN low for 5 cycles with redIn=8'hFF → all outputs at reset values; release → X reads 0,1,2… and VGA_BLANK_N=1 with VGA_R=8'hFF one cycle after release.
- Horizontal sync: one line with Y=0 → VGA_HS=1 in the cycles after X=1328..1439 (112 cycles), 0 otherwise. VGA_BLANK_N falls the cycle after X=1280.
- Line/frame wrap: X=1687,Y=1065 → next edge X=0,Y=0. X=1687,Y=5 → X=0,Y=6.
- Blank gating: redIn=greenIn=blueIn=8'hFF held constant → VGA_R/G/B=0 for every output cycle where X ≥ 1280 or Y ≥ 1024, 8'hFF elsewhere.
- Vertical sync and tick: over 2 full frames, VGA_VS is high for exactly 3×1688 cycles per frame, starting on the cycle after (0,1025). frameTick pulses exactly twice, 1,799,408 cycles apart.
- Mid-frame reset: assert resetN low at X=700,Y=400 for 3 cycles → outputs go to reset values asynchronously; after release, first frameTick arrives 1024×1688+1 cycles later.
